alarm_display_ctrl: RTL and testbench
=====================================

// Module: alarm_display_ctrl
// PURPOSE
//  Moore/Mealy FSM sequencing the 4-digit alarm-clock display and keypad entry.
//  Drives show_a / show_current_time into the 4-digit LCD driver.
//  Drives shift into the key shift register, and load_new_a / load_new_c into the alarm and time registers.
//  Aborts an unfinished key entry after TIMEOUT_S idle seconds.
// PARAMETERS
//  TIMEOUT_S  10  idle seconds allowed during key entry before abort (1..2**CNT_W-1)
//  CNT_W      4   width of the timeout second counter
//  NOKEY      4'hA  key code meaning "no key pressed"
// PORTS
//  clock              in   1  system clock, all state updates on posedge
//  reset              in   1  synchronous, active-high
//  one_second         in   1  one-clock pulse per second from the timebase
//  alarm_button       in   1  level, held while pressed
//  time_button        in   1  level, held while pressed
//  key                in   4  keypad code 0..9, NOKEY when idle
//  show_a             out  1  display alarm time
//  show_current_time  out  1  display keypad entry (maps to driver show_new_time)
//  shift              out  1  one-cycle pulse: shift key into entry register
//  load_new_a         out  1  one-cycle pulse: copy entry into alarm register
//  load_new_c         out  1  one-cycle pulse: copy entry into current time
//  time_out           out  1  high while timeout counter == TIMEOUT_S
// BEHAVIOUR
//  - Reset: state=SHOW_TIME, counter=0; every output 0 in the same cycle reset is sampled high.
//  - States: SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTRY, SHOW_ALARM (one-hot-safe encoding; illegal -> SHOW_TIME).
//  - SHOW_TIME:
//     - alarm_button -> SHOW_ALARM.
//     - else key!=NOKEY -> KEY_STORED.
//     - else stay. All outputs 0.
//  - KEY_STORED: shift=1 (Moore, exactly 1 cycle); unconditional -> KEY_WAITED.
//  - KEY_WAITED: waits for key release, no outputs.
//     - time_out -> SHOW_TIME.
//     - else key==NOKEY -> KEY_ENTRY.
//  - KEY_ENTRY: show_current_time=1 (Moore). Priority order:
//     - alarm_button: load_new_a=1 this cycle (Mealy) -> SHOW_TIME.
//     - time_button: load_new_c=1 this cycle (Mealy) -> SHOW_TIME.
//     - time_out -> SHOW_TIME, no load.
//     - key!=NOKEY -> KEY_STORED.
//  - Simultaneous alarm_button and time_button in KEY_ENTRY: only load_new_a fires.
//  - SHOW_ALARM: show_a=1 (Moore); !alarm_button -> SHOW_TIME; keys ignored.
//  - Timeout counter:
//     - Cleared to 0 whenever state is SHOW_TIME or KEY_STORED.
//     - In KEY_WAITED/KEY_ENTRY, +1 on one_second; saturates at TIMEOUT_S, no wrap.
//     - time_out = (count==TIMEOUT_S), combinational from the register.
//     - Each new key press restarts the timeout window.
//  - Latency: key press -> shift 1 cycle later.
//  - Button in KEY_ENTRY -> load pulse same cycle, show_current_time drops next cycle.
//  - Reset mid-entry: returns to SHOW_TIME next edge; no load pulse is emitted.
//  - show_a and show_current_time are never high together.
// STRUCTURE
//  - Shared package/include alarm_defs: state encodings, NOKEY, default TIMEOUT_S.
//    The key-shift register and LCD driver reuse NOKEY from it.
//  - Sub-module timeout_counter (clock, reset, clear, tick, time_out; params TIMEOUT_S, CNT_W).
//  - FSM uses separate next-state and output always blocks.
// TESTING
//  1. Reset: assert reset 2 cycles mid-KEY_ENTRY -> SHOW_TIME, all outputs 0, counter 0.
//  2. Entry then time set:
//     - Stimulus: key=1,NOKEY,2,NOKEY,3,NOKEY,4,NOKEY, then time_button.
//     - Response: 4 shift pulses, then one load_new_c pulse; show_current_time high from first release until the load.
//  3. Alarm set: same entry then alarm_button -> one load_new_a, no load_new_c; with both buttons -> only load_new_a.
//  4. Timeout:
//     - Stimulus: one key, then 10 one_second pulses idle.
//     - Response: time_out on the 10th pulse, SHOW_TIME next cycle, no load.
//     - A key after 9 pulses restarts the count at 0.
//  5. Show alarm: alarm_button held 5 cycles from SHOW_TIME -> show_a high for that span; keys during it produce no shift.
//  6. Held key: key=7 held 20 cycles in SHOW_TIME -> exactly one shift, FSM stays KEY_WAITED until release.

Source files
------------

// File: rtl/alarm_display_ctrl_pkg.sv
// Shared definitions for the alarm-clock display slice: FSM state encodings,
// the keypad idle code and the default key-entry timeout.
package alarm_defs;

  localparam logic [3:0] NOKEY         = 4'hA;
  localparam int         TIMEOUT_S_DEF = 10;

  // One-hot so that any corrupted pattern is distinguishable and recovers to SHOW_TIME.
  typedef enum logic [4:0] {
    SHOW_TIME  = 5'b00001,
    KEY_STORED = 5'b00010,
    KEY_WAITED = 5'b00100,
    KEY_ENTRY  = 5'b01000,
    SHOW_ALARM = 5'b10000
  } state_t;

endpackage

// File: rtl/alarm_display_ctrl_if.sv
// Keypad/button inputs and display/register control outputs of the alarm display controller.
// master drives the buttons and keypad; slave is the controller.
interface alarm_display_ctrl_if;

  logic       one_second;
  logic       alarm_button;
  logic       time_button;
  logic [3:0] key;
  logic       show_a;
  logic       show_current_time;
  logic       shift;
  logic       load_new_a;
  logic       load_new_c;
  logic       time_out;

  modport master (
    output one_second, alarm_button, time_button, key,
    input  show_a, show_current_time, shift, load_new_a, load_new_c, time_out
  );

  modport slave (
    input  one_second, alarm_button, time_button, key,
    output show_a, show_current_time, shift, load_new_a, load_new_c, time_out
  );

endinterface

// File: rtl/alarm_display_ctrl_timeout_counter.sv
// Idle-second counter for key entry: saturates at TIMEOUT_S, time_out decoded from the register.
// Clear wins over tick; no backpressure.
module timeout_counter #(
  parameter int TIMEOUT_S = 10,
  parameter int CNT_W     = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic time_out
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_S);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign time_out = (count == LIMIT);

endmodule

// File: rtl/alarm_display_ctrl.sv
// Alarm-clock display/keypad sequencer: shift one cycle after a key press, load pulses in the
// same cycle as the button in KEY_ENTRY; inputs are sampled every cycle, no backpressure.
module alarm_display_ctrl #(
  parameter int         TIMEOUT_S = alarm_defs::TIMEOUT_S_DEF,
  parameter int         CNT_W     = 4,
  parameter logic [3:0] NOKEY     = alarm_defs::NOKEY
) (
  input logic                 clock,
  input logic                 reset,
  alarm_display_ctrl_if.slave bus
);

  import alarm_defs::*;

  state_t state;
  state_t next_state;
  logic   cnt_clear;
  logic   cnt_tick;
  logic   time_out;
  logic   show_a;
  logic   show_current_time;
  logic   shift;
  logic   load_new_a;
  logic   load_new_c;

  assign cnt_clear = (state == SHOW_TIME) || (state == KEY_STORED);
  assign cnt_tick  = bus.one_second && ((state == KEY_WAITED) || (state == KEY_ENTRY));

  timeout_counter #(
    .TIMEOUT_S (TIMEOUT_S),
    .CNT_W     (CNT_W)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clear    (cnt_clear),
    .tick     (cnt_tick),
    .time_out (time_out)
  );

  always_comb begin
    next_state = SHOW_TIME;
    case (state)
      SHOW_TIME: begin
        if (bus.alarm_button)       next_state = SHOW_ALARM;
        else if (bus.key != NOKEY)  next_state = KEY_STORED;
      end
      KEY_STORED: next_state = KEY_WAITED;
      KEY_WAITED: begin
        if (time_out)               next_state = SHOW_TIME;
        else if (bus.key == NOKEY)  next_state = KEY_ENTRY;
        else                        next_state = KEY_WAITED;
      end
      KEY_ENTRY: begin
        if (bus.alarm_button || bus.time_button || time_out) next_state = SHOW_TIME;
        else if (bus.key != NOKEY)  next_state = KEY_STORED;
        else                        next_state = KEY_ENTRY;
      end
      SHOW_ALARM: next_state = bus.alarm_button ? SHOW_ALARM : SHOW_TIME;
      default:    next_state = SHOW_TIME;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= SHOW_TIME;
    else       state <= next_state;
  end

  // Reset is synchronous, so outputs are masked to keep them quiet in the cycle it is sampled.
  always_comb begin
    show_a            = 1'b0;
    show_current_time = 1'b0;
    shift             = 1'b0;
    load_new_a        = 1'b0;
    load_new_c        = 1'b0;
    if (!reset) begin
      case (state)
        KEY_STORED: shift = 1'b1;
        KEY_ENTRY: begin
          show_current_time = 1'b1;
          if (bus.alarm_button)     load_new_a = 1'b1;
          else if (bus.time_button) load_new_c = 1'b1;
        end
        SHOW_ALARM: show_a = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.show_a            = show_a;
  assign bus.show_current_time = show_current_time;
  assign bus.shift             = shift;
  assign bus.load_new_a        = load_new_a;
  assign bus.load_new_c        = load_new_c;
  assign bus.time_out          = time_out && !reset;

endmodule

// File: tb/tb_alarm_display_ctrl.sv
// Scoreboard bench for alarm_display_ctrl: a mode-level reference model predicts every cycle's
// outputs into a queue; a negedge monitor pops and compares them.
module tb_alarm_display_ctrl;

  localparam int         T  = 10;
  localparam logic [3:0] NK = 4'hA;

  logic clock = 1'b0;
  logic reset = 1'b1;

  alarm_display_ctrl_if bus();

  alarm_display_ctrl #(
    .TIMEOUT_S (T),
    .CNT_W     (4),
    .NOKEY     (NK)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic show_a;
    logic show_ct;
    logic shift;
    logic lna;
    logic lnc;
    logic tout;
  } exp_t;

  typedef enum {M_IDLE, M_GOT, M_REL, M_ENTRY, M_ALARM} mode_t;

  exp_t  exp_q[$];
  mode_t m_mode = M_IDLE;
  int    m_secs = 0;
  int    checks = 0;
  int    errors = 0;
  int    obs_shift = 0, obs_lna = 0, obs_lnc = 0, obs_show_a = 0;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endfunction

  // Reference: mode of the entry dialogue plus idle seconds elapsed while waiting for input.
  task automatic model(input logic r, input logic os, input logic ab, input logic tbtn,
                       input logic [3:0] k);
    exp_t  e;
    mode_t nm;
    bit    to;
    e  = '0;
    nm = m_mode;
    to = (m_secs == T);
    if (r) begin
      nm = M_IDLE;
    end else begin
      e.tout = to;
      case (m_mode)
        M_IDLE:  if (ab) nm = M_ALARM; else if (k != NK) nm = M_GOT;
        M_GOT:   begin e.shift = 1'b1; nm = M_REL; end
        M_REL:   if (to) nm = M_IDLE; else if (k == NK) nm = M_ENTRY;
        M_ENTRY: begin
          e.show_ct = 1'b1;
          if (ab)            begin e.lna = 1'b1; nm = M_IDLE; end
          else if (tbtn)     begin e.lnc = 1'b1; nm = M_IDLE; end
          else if (to)       nm = M_IDLE;
          else if (k != NK)  nm = M_GOT;
        end
        M_ALARM: begin e.show_a = 1'b1; if (!ab) nm = M_IDLE; end
        default: nm = M_IDLE;
      endcase
    end
    if (r || m_mode == M_IDLE || m_mode == M_GOT) m_secs = 0;
    else if (os && (m_mode == M_REL || m_mode == M_ENTRY) && m_secs < T) m_secs++;
    exp_q.push_back(e);
    m_mode = nm;
  endtask

  task automatic step(input logic r, input logic os, input logic ab, input logic tbtn,
                      input logic [3:0] k);
    @(posedge clock);
    #1;
    reset            = r;
    bus.one_second   = os;
    bus.alarm_button = ab;
    bus.time_button  = tbtn;
    bus.key          = k;
    model(r, os, ab, tbtn, k);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, NK);
  endtask

  task automatic enter_key(input logic [3:0] d);
    step(1'b0, 1'b0, 1'b0, 1'b0, d);
    idle(2);
  endtask

  task automatic seconds(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, NK);
      step(1'b0, 1'b0, 1'b0, 1'b0, NK);
    end
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("show_a",            int'(bus.show_a),            int'(e.show_a));
        chk("show_current_time", int'(bus.show_current_time), int'(e.show_ct));
        chk("shift",             int'(bus.shift),             int'(e.shift));
        chk("load_new_a",        int'(bus.load_new_a),        int'(e.lna));
        chk("load_new_c",        int'(bus.load_new_c),        int'(e.lnc));
        chk("time_out",          int'(bus.time_out),          int'(e.tout));
        obs_shift  += int'(bus.shift);
        obs_lna    += int'(bus.load_new_a);
        obs_lnc    += int'(bus.load_new_c);
        obs_show_a += int'(bus.show_a);
      end
    end
  end

  initial begin : stim
    int s0, a0, c0, sa0;
    bus.one_second   = 1'b0;
    bus.alarm_button = 1'b0;
    bus.time_button  = 1'b0;
    bus.key          = NK;

    step(1'b1, 1'b0, 1'b0, 1'b0, NK);
    step(1'b1, 1'b0, 1'b0, 1'b0, NK);
    idle(2);

    // Reset in the middle of an entry with some idle seconds accumulated.
    enter_key(4'd5);
    seconds(3);
    step(1'b1, 1'b0, 1'b0, 1'b1, NK);
    step(1'b1, 1'b0, 1'b1, 1'b0, NK);
    idle(3);

    // Four digits then time set.
    settle(); s0 = obs_shift; a0 = obs_lna; c0 = obs_lnc;
    for (int d = 1; d <= 4; d++) enter_key(4'(d));
    step(1'b0, 1'b0, 1'b0, 1'b1, NK);
    idle(3);
    settle();
    chk("time_set_shifts", obs_shift - s0, 4);
    chk("time_set_load_c", obs_lnc - c0, 1);
    chk("time_set_load_a", obs_lna - a0, 0);

    // Four digits then alarm set.
    a0 = obs_lna; c0 = obs_lnc;
    for (int d = 1; d <= 4; d++) enter_key(4'(d));
    step(1'b0, 1'b0, 1'b1, 1'b0, NK);
    idle(3);
    settle();
    chk("alarm_set_load_a", obs_lna - a0, 1);
    chk("alarm_set_load_c", obs_lnc - c0, 0);

    // Both buttons together: alarm load has priority.
    a0 = obs_lna; c0 = obs_lnc;
    for (int d = 6; d <= 9; d++) enter_key(4'(d));
    step(1'b0, 1'b0, 1'b1, 1'b1, NK);
    idle(3);
    settle();
    chk("both_btn_load_a", obs_lna - a0, 1);
    chk("both_btn_load_c", obs_lnc - c0, 0);

    // Timeout after ten idle seconds, then restart of the window by a new key.
    a0 = obs_lna; c0 = obs_lnc;
    enter_key(4'd2);
    seconds(10);
    idle(3);
    enter_key(4'd3);
    seconds(9);
    enter_key(4'd4);
    seconds(9);
    step(1'b0, 1'b0, 1'b0, 1'b1, NK);
    idle(2);
    settle();
    chk("timeout_no_load_a", obs_lna - a0, 0);
    chk("restart_load_c",    obs_lnc - c0, 1);

    // Alarm display held five cycles with keys pressed meanwhile.
    s0 = obs_shift; sa0 = obs_show_a;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 4'(i));
    idle(3);
    settle();
    chk("show_alarm_cycles", obs_show_a - sa0, 5);
    chk("show_alarm_shifts", obs_shift - s0, 0);

    // Key held for twenty cycles produces a single shift.
    s0 = obs_shift;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd7);
    idle(2);
    step(1'b0, 1'b0, 1'b0, 1'b1, NK);
    idle(2);
    settle();
    chk("held_key_shifts", obs_shift - s0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic       r, os, ab, tbtn;
      logic [3:0] k;
      r    = ($urandom_range(0, 199) == 0);
      os   = ($urandom_range(0, 3) == 0);
      ab   = ($urandom_range(0, 11) == 0);
      tbtn = ($urandom_range(0, 9) == 0);
      k    = ($urandom_range(0, 9) < 6) ? NK : 4'($urandom_range(0, 9));
      step(r, os, ab, tbtn, k);
    end
    idle(2);
    settle();
    settle();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
